// File: rtl/conv_pkg.sv
// Shared types and arithmetic helpers for the convolution layer engine and later layers.
// The saturate/ReLU helper works on a wide signed value so any lane width can reuse it.
package conv_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LD_FILT,
    LD_WIN,
    MAC,
    WR,
    SHIFT,
    FINISH
  } state_e;

  localparam int N_FILT_DEF = 4;
  localparam int K_DEF      = 4;
  localparam int DW_DEF     = 8;
  localparam int AW_DEF     = 12;
  localparam int QSH_DEF    = 4;

  function automatic int accW(input int dw, input int k);
    return 2 * dw + $clog2(k);
  endfunction

  localparam int ACC_W = accW(DW_DEF, K_DEF);

  // Truncating arithmetic shift, clamp to the signed dw-bit range, then optional ReLU.
  function automatic logic signed [63:0] satRelu(input logic signed [63:0] acc,
                                                 input int qsh,
                                                 input int dw,
                                                 input logic reluEn);
    logic signed [63:0] res;
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    res = acc >>> qsh;
    hi  = (64'sd1 <<< (dw - 1)) - 64'sd1;
    lo  = -(64'sd1 <<< (dw - 1));
    if (res > hi) begin
      res = hi;
    end else if (res < lo) begin
      res = lo;
    end
    if (reluEn && (res < 64'sd0)) begin
      res = 64'sd0;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_layer_engine_if.sv
// Sequencer + feature-memory bundle of the convolution engine.
// The engine uses the slave modport; the sequencer/memory side uses master.
interface conv_layer_engine_if #(
  parameter int AW = 12,
  parameter int DW = 8
);
  logic          start;
  logic [AW-1:0] ifm_base;
  logic [AW-1:0] ifm_len;
  logic [AW-1:0] filt_base;
  logic [AW-1:0] ofm_base;
  logic [2:0]    stride;
  logic          relu_en;
  logic          rd_en;
  logic [AW-1:0] rd_addr;
  logic [DW-1:0] rd_data;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic          busy;
  logic          done;

  modport master (
    output start, ifm_base, ifm_len, filt_base, ofm_base, stride, relu_en, rd_data,
    input  rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );

  modport slave (
    input  start, ifm_base, ifm_len, filt_base, ofm_base, stride, relu_en, rd_data,
    output rd_en, rd_addr, wr_en, wr_addr, wr_data, busy, done
  );
endinterface

// File: rtl/conv_mac_lane.sv
// One MAC lane: a K-tap weight bank, a signed accumulator and the shared sat/ReLU stage.
// Weights are written one-hot per tap; tapSel_i picks the weight matching the broadcast window word.
module conv_mac_lane
  import conv_pkg::*;
#(
  parameter int K     = 4,
  parameter int DW    = 8,
  parameter int ACC_W = 18,
  parameter int QSH   = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [K-1:0]         wEn_i,
  input  logic signed [DW-1:0] wData_i,
  input  logic                 macEn_i,
  input  logic                 macClr_i,
  input  logic [K-1:0]         tapSel_i,
  input  logic signed [DW-1:0] winData_i,
  input  logic                 reluEn_i,
  output logic signed [DW-1:0] res_o
);

  logic signed [DW-1:0]    weight_q [K];
  logic signed [DW-1:0]    wSel;
  logic signed [2*DW-1:0]  prod;
  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;

  always_comb begin
    wSel = '0;
    for (int t = 0; t < K; t++) begin
      if (tapSel_i[t]) begin
        wSel = weight_q[t];
      end
    end
    prod  = winData_i * wSel;
    acc_d = macClr_i ? ACC_W'(prod) : acc_q + ACC_W'(prod);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_q <= '0;
      for (int t = 0; t < K; t++) begin
        weight_q[t] <= '0;
      end
    end else begin
      for (int t = 0; t < K; t++) begin
        if (wEn_i[t]) begin
          weight_q[t] <= wData_i;
        end
      end
      if (macEn_i) begin
        acc_q <= acc_d;
      end
    end
  end

  assign res_o = DW'(satRelu(64'(acc_q), QSH, DW, reluEn_i));

endmodule

// File: rtl/conv_layer_engine.sv
// 1-D convolution layer: loads N_FILT filters, slides a K-word window over one IFMap row
// and writes N_FILT saturated results per window. Window buffer, counters and FSM live here.
module conv_layer_engine
  import conv_pkg::*;
#(
  parameter int N_FILT = 4,
  parameter int K      = 4,
  parameter int DW     = 8,
  parameter int AW     = 12,
  parameter int QSH    = 4
) (
  input logic               clk,
  input logic               rst,
  conv_layer_engine_if.slave bus_if
);

  localparam int LANE_ACC_W = accW(DW, K);
  localparam int CW         = $clog2(N_FILT * K + K + 8) + 1;
  localparam int OW         = AW + 8;

  state_e               state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [AW-1:0]        rdPtr_q, rdPtr_d;
  logic [AW-1:0]        ofmPtr_q, ofmPtr_d;
  logic [OW-1:0]        winStart_q, winStart_d;
  logic [AW-1:0]        filtBase_q;
  logic [AW-1:0]        ifmLen_q;
  logic [2:0]           stride_q;
  logic                 reluEn_q;
  logic                 rdPend_q;
  logic [CW-1:0]        rdTag_q;
  logic signed [DW-1:0] win_q [K];

  logic                 cfgLoad, capFilt, capWin;
  logic                 rdEn, wrEn, busy, done, macEn, macClr;
  logic [AW-1:0]        rdAddr, wrAddr;
  logic [DW-1:0]        wrData;
  logic [K-1:0]         wEn [N_FILT];
  logic [K-1:0]         tapSel;
  logic signed [DW-1:0] winWord;
  logic signed [DW-1:0] laneRes [N_FILT];

  assign cfgLoad = (state_q == IDLE) && bus_if.start;
  assign capFilt = rdPend_q && (state_q == LD_FILT);
  assign capWin  = rdPend_q && ((state_q == LD_WIN) || (state_q == SHIFT));

  always_comb begin
    for (int f = 0; f < N_FILT; f++) begin
      for (int t = 0; t < K; t++) begin
        wEn[f][t] = capFilt && (rdTag_q == CW'(f * K + t));
      end
    end
    winWord = '0;
    for (int t = 0; t < K; t++) begin
      tapSel[t] = (cnt_q == CW'(t));
      if (tapSel[t]) begin
        winWord = win_q[t];
      end
    end
  end

  for (genvar f = 0; f < N_FILT; f++) begin : g_lane
    conv_mac_lane #(
      .K    (K),
      .DW   (DW),
      .ACC_W(LANE_ACC_W),
      .QSH  (QSH)
    ) u_lane (
      .clk      (clk),
      .rst      (rst),
      .wEn_i    (wEn[f]),
      .wData_i  (bus_if.rd_data),
      .macEn_i  (macEn),
      .macClr_i (macClr),
      .tapSel_i (tapSel),
      .winData_i(winWord),
      .reluEn_i (reluEn_q),
      .res_o    (laneRes[f])
    );
  end

  // Reads are issued while the counter is below the transfer count; the extra
  // cycle at the top of each load state captures the last returned word.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    rdPtr_d    = rdPtr_q;
    ofmPtr_d   = ofmPtr_q;
    winStart_d = winStart_q;
    rdEn       = 1'b0;
    rdAddr     = '0;
    wrEn       = 1'b0;
    wrAddr     = '0;
    wrData     = '0;
    busy       = 1'b0;
    done       = 1'b0;
    macEn      = 1'b0;
    macClr     = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus_if.start) begin
          cnt_d      = '0;
          rdPtr_d    = bus_if.ifm_base;
          ofmPtr_d   = bus_if.ofm_base;
          winStart_d = '0;
          state_d    = (bus_if.ifm_len < AW'(K)) ? FINISH : LD_FILT;
        end
      end
      LD_FILT: begin
        busy = 1'b1;
        if (cnt_q < CW'(N_FILT * K)) begin
          rdEn   = 1'b1;
          rdAddr = filtBase_q + AW'(cnt_q);
          cnt_d  = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = LD_WIN;
        end
      end
      LD_WIN: begin
        busy = 1'b1;
        if (cnt_q < CW'(K)) begin
          rdEn    = 1'b1;
          rdAddr  = rdPtr_q;
          rdPtr_d = rdPtr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = MAC;
        end
      end
      MAC: begin
        busy   = 1'b1;
        macEn  = 1'b1;
        macClr = (cnt_q == '0);
        if (cnt_q == CW'(K - 1)) begin
          cnt_d   = '0;
          state_d = WR;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      WR: begin
        busy     = 1'b1;
        wrEn     = 1'b1;
        wrAddr   = ofmPtr_q;
        ofmPtr_d = ofmPtr_q + 1'b1;
        for (int f = 0; f < N_FILT; f++) begin
          if (cnt_q == CW'(f)) begin
            wrData = laneRes[f];
          end
        end
        if (cnt_q == CW'(N_FILT - 1)) begin
          cnt_d = '0;
          if (winStart_q + OW'(stride_q) + OW'(K) <= OW'(ifmLen_q)) begin
            winStart_d = winStart_q + OW'(stride_q);
            state_d    = SHIFT;
          end else begin
            state_d = FINISH;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      SHIFT: begin
        busy = 1'b1;
        if (cnt_q < CW'(stride_q)) begin
          rdEn    = 1'b1;
          rdAddr  = rdPtr_q;
          rdPtr_d = rdPtr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
        end else begin
          cnt_d   = '0;
          state_d = MAC;
        end
      end
      FINISH: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      rdPtr_q    <= '0;
      ofmPtr_q   <= '0;
      winStart_q <= '0;
      filtBase_q <= '0;
      ifmLen_q   <= '0;
      stride_q   <= 3'd1;
      reluEn_q   <= 1'b0;
      rdPend_q   <= 1'b0;
      rdTag_q    <= '0;
      for (int t = 0; t < K; t++) begin
        win_q[t] <= '0;
      end
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rdPtr_q    <= rdPtr_d;
      ofmPtr_q   <= ofmPtr_d;
      winStart_q <= winStart_d;
      rdPend_q   <= rdEn;
      rdTag_q    <= cnt_q;
      if (cfgLoad) begin
        filtBase_q <= bus_if.filt_base;
        ifmLen_q   <= bus_if.ifm_len;
        stride_q   <= (bus_if.stride == 3'd0) ? 3'd1 : bus_if.stride;
        reluEn_q   <= bus_if.relu_en;
      end
      // Newest word enters at the top tap so tap 0 always holds the oldest.
      if (capWin) begin
        for (int t = 0; t < K - 1; t++) begin
          win_q[t] <= win_q[t + 1];
        end
        win_q[K-1] <= bus_if.rd_data;
      end
    end
  end

  assign bus_if.rd_en   = rdEn;
  assign bus_if.rd_addr = rdAddr;
  assign bus_if.wr_en   = wrEn;
  assign bus_if.wr_addr = wrAddr;
  assign bus_if.wr_data = wrData;
  assign bus_if.busy    = busy;
  assign bus_if.done    = done;

endmodule

// File: tb/tb_conv_layer_engine.sv
// Directed bench for conv_layer_engine: a small feature memory model, hand-computed
// expected OFM words, strobe/done bookkeeping sampled on the falling edge.
module tb_conv_layer_engine;
  import conv_pkg::*;

  localparam int IFM = 256;
  localparam int FLT = 512;
  localparam int OFM = 768;

  logic clk = 1'b0;
  logic rst;

  conv_layer_engine_if #(.AW(12), .DW(8)) bus ();

  conv_layer_engine #(
    .N_FILT(4),
    .K     (4),
    .DW    (8),
    .AW    (12),
    .QSH   (4)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .bus_if(bus)
  );

  always #5 clk = ~clk;

  logic [7:0] mem [4096];

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rd_data <= '0;
    end else if (bus.rd_en) begin
      bus.rd_data <= mem[bus.rd_addr];
    end
  end

  int vecCnt = 0;
  int missCnt = 0;
  int cycNo = 0;
  int startCyc = 0;
  int rdCount = 0;
  int wrCount = 0;
  int doneCount = 0;
  int doneAt = -1;
  int busyAtDone = 0;
  int overlap = 0;
  int wrAddrLog [64];
  int wrDataLog [64];

  task automatic checkOutput(input string tag, input int observed, input int expected);
    vecCnt++;
    if (observed != expected) begin
      missCnt++;
      $display("[TB] FAIL %s: observed %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic int memAt(input int a);
    logic [11:0] ad;
    ad = 12'(a);
    return int'($signed(mem[ad]));
  endfunction

  task automatic memPut(input int a, input int v);
    logic [11:0] ad;
    ad = 12'(a);
    mem[ad] = 8'(v);
  endtask

  task automatic clearOfm();
    for (int i = 0; i < 64; i++) memPut(OFM + i, 85);
  endtask

  task automatic loadFilt(input int f, input int w0, input int w1, input int w2, input int w3);
    memPut(FLT + f * 4 + 0, w0);
    memPut(FLT + f * 4 + 1, w1);
    memPut(FLT + f * 4 + 2, w2);
    memPut(FLT + f * 4 + 3, w3);
  endtask

  // One cycle: memory-side writes and strobe bookkeeping away from the active edge.
  task automatic stepCycle();
    @(negedge clk);
    cycNo++;
    if (bus.rd_en) rdCount++;
    if (bus.rd_en && bus.wr_en) overlap++;
    if (bus.wr_en) begin
      mem[bus.wr_addr] = bus.wr_data;
      if (wrCount < 64) begin
        wrAddrLog[wrCount] = int'(bus.wr_addr);
        wrDataLog[wrCount] = int'($signed(bus.wr_data));
      end
      wrCount++;
    end
    if (bus.done) begin
      doneCount++;
      if (doneAt < 0) doneAt = cycNo - startCyc;
      if (bus.busy) busyAtDone++;
    end
  endtask

  task automatic applyStimulus(input int len, input int strd, input bit relu, input bit restart);
    rdCount    = 0;
    wrCount    = 0;
    doneCount  = 0;
    doneAt     = -1;
    busyAtDone = 0;
    overlap    = 0;
    bus.ifm_base  = 12'(IFM);
    bus.ifm_len   = 12'(len);
    bus.filt_base = 12'(FLT);
    bus.ofm_base  = 12'(OFM);
    bus.stride    = 3'(strd);
    bus.relu_en   = relu;
    bus.start     = 1'b1;
    startCyc = cycNo;
    stepCycle();
    bus.start = 1'b0;
    if (restart) begin
      bus.ifm_base  = '0;
      bus.filt_base = '0;
      bus.ofm_base  = 12'h400;
      bus.stride    = 3'd3;
      bus.ifm_len   = 12'd2;
      bus.relu_en   = 1'b1;
    end
    for (int n = 0; n < 2000 && doneCount == 0; n++) begin
      bus.start = restart && (n == 4);
      stepCycle();
    end
    bus.start = 1'b0;
    checkOutput("run_done_seen", int'(doneCount > 0), 1);
    repeat (8) stepCycle();
  endtask

  initial begin
    int n;
    int e2 [5][4];
    int e3 [3][4];
    int e7 [2][4];
    e2 = '{'{10, 1, -4, -1}, '{14, 2, -5, -1}, '{18, 3, -6, -1}, '{22, 4, -7, -1}, '{26, 5, -8, -1}};
    e3 = '{'{10, 1, -4, -1}, '{18, 3, -6, -1}, '{26, 5, -8, -1}};
    e7 = '{'{10, 1, -4, -1}, '{30, 6, -9, -1}};

    rst = 1'b1;
    bus.start = 1'b0;
    bus.ifm_base = '0;
    bus.ifm_len = '0;
    bus.filt_base = '0;
    bus.ofm_base = '0;
    bus.stride = '0;
    bus.relu_en = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    for (int i = 0; i < 12; i++) memPut(IFM + i, i + 1);
    // Weights of 16 cancel the QSH=4 shift, so lane 0 yields the plain window sum.
    loadFilt(0, 16, 16, 16, 16);
    loadFilt(1, 16, 0, 0, 0);
    loadFilt(2, 0, 0, 0, -16);
    loadFilt(3, 16, -16, 0, 0);
    clearOfm();

    repeat (3) stepCycle();
    checkOutput("rst_rd_en", int'(bus.rd_en), 0);
    checkOutput("rst_wr_en", int'(bus.wr_en), 0);
    checkOutput("rst_busy", int'(bus.busy), 0);
    checkOutput("rst_done", int'(bus.done), 0);
    checkOutput("rst_rd_addr", int'(bus.rd_addr), 0);
    checkOutput("rst_wr_addr", int'(bus.wr_addr), 0);
    checkOutput("rst_wr_data", int'(bus.wr_data), 0);
    rst = 1'b0;
    stepCycle();

    $display("[TB] reset during MAC");
    bus.ifm_base  = 12'(IFM);
    bus.ifm_len   = 12'd8;
    bus.filt_base = 12'(FLT);
    bus.ofm_base  = 12'(OFM);
    bus.stride    = 3'd1;
    bus.start     = 1'b1;
    stepCycle();
    bus.start = 1'b0;
    n = 0;
    while (dut.state_q != MAC && n < 200) begin
      stepCycle();
      n++;
    end
    checkOutput("rst_reach_mac", int'(dut.state_q == MAC), 1);
    stepCycle();
    stepCycle();
    checkOutput("mac_busy_before_rst", int'(bus.busy), 1);
    doneCount = 0;
    wrCount = 0;
    #1 rst = 1'b1;
    #1;
    checkOutput("midrst_rd_en", int'(bus.rd_en), 0);
    checkOutput("midrst_wr_en", int'(bus.wr_en), 0);
    checkOutput("midrst_busy", int'(bus.busy), 0);
    repeat (2) stepCycle();
    rst = 1'b0;
    repeat (5) stepCycle();
    checkOutput("midrst_no_done", doneCount, 0);
    checkOutput("midrst_no_write", wrCount, 0);

    $display("[TB] stride 1, len 8");
    clearOfm();
    applyStimulus(8, 1, 1'b0, 1'b0);
    checkOutput("s1_done_count", doneCount, 1);
    checkOutput("s1_busy_at_done", busyAtDone, 0);
    checkOutput("s1_writes", wrCount, 20);
    checkOutput("s1_reads", rdCount, 24);
    checkOutput("s1_overlap", overlap, 0);
    checkOutput("s1_first_addr", wrAddrLog[0], OFM);
    checkOutput("s1_first_data", wrDataLog[0], 10);
    for (int w = 0; w < 5; w++)
      for (int f = 0; f < 4; f++)
        checkOutput($sformatf("s1_w%0d_l%0d", w, f), memAt(OFM + w * 4 + f), e2[w][f]);

    $display("[TB] stride 2, len 8");
    clearOfm();
    applyStimulus(8, 2, 1'b0, 1'b0);
    checkOutput("s2_done_count", doneCount, 1);
    checkOutput("s2_writes", wrCount, 12);
    checkOutput("s2_reads", rdCount, 24);
    checkOutput("s2_no_extra", memAt(OFM + 12), 85);
    for (int w = 0; w < 3; w++)
      for (int f = 0; f < 4; f++)
        checkOutput($sformatf("s2_w%0d_l%0d", w, f), memAt(OFM + w * 4 + f), e3[w][f]);

    $display("[TB] stride 5 exceeds K, len 12");
    clearOfm();
    applyStimulus(12, 5, 1'b0, 1'b0);
    checkOutput("s5_writes", wrCount, 8);
    checkOutput("s5_reads", rdCount, 25);
    for (int w = 0; w < 2; w++)
      for (int f = 0; f < 4; f++)
        checkOutput($sformatf("s5_w%0d_l%0d", w, f), memAt(OFM + w * 4 + f), e7[w][f]);

    $display("[TB] short row, no traffic");
    applyStimulus(3, 1, 1'b0, 1'b0);
    checkOutput("short_reads", rdCount, 0);
    checkOutput("short_writes", wrCount, 0);
    checkOutput("short_done_count", doneCount, 1);
    checkOutput("short_done_within_3", int'(doneAt >= 1 && doneAt <= 3), 1);

    $display("[TB] stride 0 with restart while busy");
    clearOfm();
    applyStimulus(8, 0, 1'b0, 1'b1);
    checkOutput("rs_done_count", doneCount, 1);
    checkOutput("rs_writes", wrCount, 20);
    checkOutput("rs_first_addr", wrAddrLog[0], OFM);
    for (int w = 0; w < 5; w++) begin
      checkOutput($sformatf("rs_w%0d_l0", w), memAt(OFM + w * 4), e2[w][0]);
      checkOutput($sformatf("rs_w%0d_l2", w), memAt(OFM + w * 4 + 2), e2[w][2]);
    end

    $display("[TB] saturation and relu");
    for (int i = 0; i < 4; i++) memPut(IFM + i, 127);
    loadFilt(0, 127, 127, 127, 127);
    loadFilt(1, -127, -127, -127, -127);
    loadFilt(2, -1, 0, 0, 0);
    loadFilt(3, 1, 0, 0, 0);
    clearOfm();
    applyStimulus(4, 1, 1'b0, 1'b0);
    checkOutput("sat_writes", wrCount, 4);
    checkOutput("sat_pos", memAt(OFM + 0), 127);
    checkOutput("sat_neg", memAt(OFM + 1), -128);
    checkOutput("trunc_neg", memAt(OFM + 2), -8);
    checkOutput("trunc_pos", memAt(OFM + 3), 7);
    clearOfm();
    applyStimulus(4, 1, 1'b1, 1'b0);
    checkOutput("relu_pos", memAt(OFM + 0), 127);
    checkOutput("relu_neg", memAt(OFM + 1), 0);
    checkOutput("relu_small_neg", memAt(OFM + 2), 0);
    checkOutput("relu_small_pos", memAt(OFM + 3), 7);

    $display("== %0d vectors applied, %0d miscompares ==", vecCnt, missCnt);
    $finish;
  end

endmodule
